// File: rtl/coreaxi4dmacontroller_int_queue.sv
// Interrupt request queue for the AXI4 DMA controller: accepts completion
// and error requests into a small FIFO, acks each once, and raises irq.
//   in : clock, resetn, intReq/errReq (+DscrptrNum), intEnable, intClr
//   out: intReqAck, errReqAck, irq, headValid, headDscrptrNum, headErr,
//        queueCount
module coreaxi4dmacontroller_int_queue #(
  parameter int DSCRPTR_NUM_WIDTH = 2,
  parameter int QUEUE_DEPTH       = 4,
  parameter int QUEUE_PTR_WIDTH   = 2
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         intReq,
  input  logic [DSCRPTR_NUM_WIDTH-1:0] intReqDscrptrNum,
  output logic                         intReqAck,
  input  logic                         errReq,
  input  logic [DSCRPTR_NUM_WIDTH-1:0] errReqDscrptrNum,
  output logic                         errReqAck,
  input  logic                         intEnable,
  input  logic                         intClr,
  output logic                         irq,
  output logic                         headValid,
  output logic [DSCRPTR_NUM_WIDTH-1:0] headDscrptrNum,
  output logic                         headErr,
  output logic [QUEUE_PTR_WIDTH:0]     queueCount
);

  localparam int DW = DSCRPTR_NUM_WIDTH;
  localparam int PW = QUEUE_PTR_WIDTH;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(QUEUE_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    ACK_INT = 3'b010,
    ACK_ERR = 3'b100
  } state_e;

  state_e        state_q, state_d;
  logic [DW:0]   mem_q [QUEUE_DEPTH];
  logic [DW:0]   mem_d [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          irq_q, irq_d;

  logic          idle;
  logic          pop;
  logic          space;
  logic          push_err;
  logic          push_int;
  logic          push;
  logic [DW:0]   wdata;
  logic [DW:0]   head_w;

  assign idle = (state_q == IDLE);
  assign pop  = intClr && (count_q != '0);
  // A full queue still takes a request when this cycle's pop frees a slot.
  assign space    = (count_q < DEPTH_C) || pop;
  assign push_err = idle && space && errReq;
  assign push_int = idle && space && !errReq && intReq;
  assign push     = push_err || push_int;
  assign wdata    = push_err ? {1'b1, errReqDscrptrNum}
                             : {1'b0, intReqDscrptrNum};

  always_comb begin
    state_d = IDLE;
    unique case (1'b1)
      state_q[0]: begin
        if (push_err)      state_d = ACK_ERR;
        else if (push_int) state_d = ACK_INT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    irq_d   = (count_d != '0) && intEnable;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
      mem_q    <= mem_d;
    end
  end

  assign head_w         = mem_q[rd_ptr_q];
  assign headValid      = (count_q != '0);
  assign headDscrptrNum = headValid ? head_w[DW-1:0] : '0;
  assign headErr        = headValid && head_w[DW];
  assign queueCount     = count_q;
  assign intReqAck      = (state_q == ACK_INT);
  assign errReqAck      = (state_q == ACK_ERR);
  assign irq            = irq_q;

endmodule
